// File: rtl/torus_ring_channel.sv
// -----------------------------------------------------------------------------
// torus_ring_channel
//
// One dimension of a torus: NUM_NODES routers on a unidirectional ring. Node i
// drives link i. Link i is LINK_DELAY register stages long and ends at node
// (i+1) mod NUM_NODES. The last node wraps back to node 0. Each node has a
// small injection FIFO and a registered ejection port.
//
// Transport inside the ring is bufferless. A flit that arrives at a node and is
// not addressed to it is forwarded into the next link in the same cycle. That
// in-transit flit always wins the outgoing slot over local injection.
//
// Handshake: a node-i injection is accepted when the offered flit has its
// valid bit (FLIT_SIZE-1) set and inject_ready[i] is high. The flit is written
// into FIFO i on that clock edge. There is no valid/ready on the ejection side.
// eject_flit simply shows a delivered flit for exactly one cycle and is
// all-zero otherwise.
//
// Ports
//   clk, rst      : single clock; synchronous, active-high reset
//   inject_flit   : node i slice [i*FLIT_SIZE +: FLIT_SIZE]
//   inject_ready  : bit i high when FIFO i can take a flit this cycle
//   eject_flit    : registered delivered flit per node, zero when idle
//   drop_count    : saturating count of flits with out-of-range destination
//   ring_busy     : any link stage or FIFO holds a valid flit
// -----------------------------------------------------------------------------
module torus_ring_channel #(
  parameter int NUM_NODES  = 4,
  parameter int LG_NODES   = 2,
  parameter int FLIT_SIZE  = 82,
  parameter int DST_LSB    = 0,
  parameter int LINK_DELAY = 1,
  parameter int INJ_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_NODES*FLIT_SIZE-1:0] inject_flit,
  output logic [NUM_NODES-1:0]           inject_ready,
  output logic [NUM_NODES*FLIT_SIZE-1:0] eject_flit,
  output logic [7:0]                     drop_count,
  output logic                           ring_busy
);

  localparam int VB = FLIT_SIZE - 1;
  localparam int AW = $clog2(INJ_DEPTH);
  localparam logic [AW:0]       CNT_FULL = (AW+1)'(INJ_DEPTH);
  localparam logic [LG_NODES:0] NODES_W  = (LG_NODES+1)'(NUM_NODES);

  // Injection FIFOs. Only the pointers and counts are reset; memory contents
  // are meaningless while the count is zero.
  logic [FLIT_SIZE-1:0]               fifo_mem_q [NUM_NODES][INJ_DEPTH];
  logic [NUM_NODES-1:0][AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [NUM_NODES-1:0][AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [NUM_NODES-1:0][AW:0]         cnt_q, cnt_d;

  // Link pipelines. link_q[i][LINK_DELAY-1] is the arrival at node i+1.
  logic [NUM_NODES-1:0][LINK_DELAY-1:0][FLIT_SIZE-1:0] link_q, link_d;

  logic [NUM_NODES-1:0][FLIT_SIZE-1:0] eject_q, eject_d;
  logic [7:0]                          drop_q, drop_d;

  // Per-node routing signals
  logic [NUM_NODES-1:0][FLIT_SIZE-1:0] arr_flit, head_flit, link_in;
  logic [NUM_NODES-1:0][LG_NODES-1:0]  arr_dst, head_dst;
  logic [NUM_NODES-1:0]                head_v, full, push, pop, drop_vec;
  logic                                link_any;
  logic [8:0]                          drop_sum;

  for (genvar g = 0; g < NUM_NODES; g++) begin : g_node
    localparam int PREV = (g == 0) ? NUM_NODES - 1 : g - 1;
    localparam logic [LG_NODES-1:0] SELF = LG_NODES'(g);

    logic arr_here, arr_pass, head_oob, head_here;

    assign arr_flit[g]  = link_q[PREV][LINK_DELAY-1];
    assign head_flit[g] = fifo_mem_q[g][rd_ptr_q[g]];
    assign arr_dst[g]   = arr_flit[g][DST_LSB +: LG_NODES];
    assign head_dst[g]  = head_flit[g][DST_LSB +: LG_NODES];

    assign full[g]         = (cnt_q[g] == CNT_FULL);
    assign head_v[g]       = (cnt_q[g] != '0);
    assign inject_ready[g] = ~rst & ~full[g];
    assign push[g]         = inject_flit[g*FLIT_SIZE + VB] & inject_ready[g];

    assign arr_here  = arr_flit[g][VB] && (arr_dst[g] == SELF);
    assign arr_pass  = arr_flit[g][VB] && (arr_dst[g] != SELF);
    assign head_oob  = ({1'b0, head_dst[g]} >= NODES_W);
    assign head_here = (head_dst[g] == SELF);

    // The head leaves whenever the outgoing slot is free. The one exception
    // is a self-addressed head: it must wait while the eject register is
    // taken by an arrival.
    assign pop[g]      = head_v[g] & ~arr_pass & (head_oob | ~head_here | ~arr_here);
    assign drop_vec[g] = pop[g] & head_oob;

    assign eject_d[g] = arr_here                         ? arr_flit[g]  :
                        (pop[g] & head_here & ~head_oob) ? head_flit[g] : '0;
    assign link_in[g] = arr_pass                         ? arr_flit[g]  :
                        (pop[g] & ~head_here & ~head_oob) ? head_flit[g] : '0;

    assign rd_ptr_d[g] = rd_ptr_q[g] + AW'(pop[g]);
    assign wr_ptr_d[g] = wr_ptr_q[g] + AW'(push[g]);
    assign cnt_d[g]    = cnt_q[g] + (AW+1)'(push[g]) - (AW+1)'(pop[g]);

    // Outputs read as idle throughout reset, including the first reset cycle
    // before the registers have cleared.
    assign eject_flit[g*FLIT_SIZE +: FLIT_SIZE] = rst ? '0 : eject_q[g];
  end

  always_comb begin
    link_d   = '0;
    link_any = 1'b0;
    for (int i = 0; i < NUM_NODES; i++) begin
      link_d[i][0] = link_in[i];
      for (int s = 1; s < LINK_DELAY; s++) begin
        link_d[i][s] = link_q[i][s-1];
      end
      for (int s = 0; s < LINK_DELAY; s++) begin
        link_any = link_any | link_q[i][s][VB];
      end
    end
  end

  // Several nodes may drop in the same cycle, so add the whole count and clamp.
  always_comb begin
    drop_sum = {1'b0, drop_q} + 9'($countones(drop_vec));
    drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      link_q   <= '0;
      eject_q  <= '0;
      drop_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      link_q   <= link_d;
      eject_q  <= eject_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NODES; i++) begin
      if (push[i]) begin
        fifo_mem_q[i][wr_ptr_q[i]] <= inject_flit[i*FLIT_SIZE +: FLIT_SIZE];
      end
    end
  end

  assign drop_count = rst ? 8'd0 : drop_q;
  assign ring_busy  = ~rst & (link_any | (|head_v));

endmodule

// File: tb/tb_torus_ring_channel.sv
// -----------------------------------------------------------------------------
// Bench for torus_ring_channel. Two instances share the clock:
//   u_dut4: default parameters (4 nodes, LINK_DELAY=1)
//   u_dut3: 3 nodes, LINK_DELAY=2; leaves dst=3 out of range
// Directed scenarios use per-cycle expected tables written from the latency
// rule (2 + hops*LINK_DELAY) and the priority rules. Random traffic is checked
// against a delivery scoreboard: every accepted flit must arrive exactly once,
// at its destination, in order per (source, destination) pair.
// Flit layout used here: [81] valid, [1:0] dst, [9:8] src, [31:16] seq,
// [71:40] payload.
// -----------------------------------------------------------------------------
module tb_torus_ring_channel;

  localparam int F    = 82;
  localparam int VB   = F - 1;
  localparam int MAXC = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst4, rst3;
  logic [4*F-1:0]   inj4, ej4;
  logic [3*F-1:0]   inj3, ej3;
  logic [3:0]       rdy4;
  logic [2:0]       rdy3;
  logic [7:0]       drop4, drop3;
  logic             busy4, busy3;

  torus_ring_channel u_dut4 (
    .clk(clk), .rst(rst4), .inject_flit(inj4), .inject_ready(rdy4),
    .eject_flit(ej4), .drop_count(drop4), .ring_busy(busy4)
  );

  torus_ring_channel #(.NUM_NODES(3), .LG_NODES(2), .LINK_DELAY(2)) u_dut3 (
    .clk(clk), .rst(rst3), .inject_flit(inj3), .inject_ready(rdy3),
    .eject_flit(ej3), .drop_count(drop3), .ring_busy(busy3)
  );

  int checks = 0;
  int errors = 0;
  int seq_n  = 0;

  logic [F-1:0]   exp_q[$];
  logic [4*F-1:0] sched_inj [MAXC];
  logic [4*F-1:0] sched_ej  [MAXC];
  logic [3:0]     sched_rdy [MAXC];

  function automatic logic [F-1:0] make_flit(input int src, input int dst);
    logic [F-1:0] f;
    logic [1:0]   s2, d2;
    logic [15:0]  q16;
    s2  = src[1:0];
    d2  = dst[1:0];
    q16 = seq_n[15:0];
    seq_n++;
    f          = '0;
    f[VB]      = 1'b1;
    f[1:0]     = d2;
    f[9:8]     = s2;
    f[31:16]   = q16;
    f[71:40]   = $urandom();
    return f;
  endfunction

  task automatic clear_sched(input int sel);
    for (int c = 0; c < MAXC; c++) begin
      sched_inj[c] = '0;
      sched_ej[c]  = '0;
      sched_rdy[c] = (sel == 4) ? 4'hF : 4'h7;
    end
  endtask

  task automatic place_inj(input int c, input int node, input logic [F-1:0] f);
    sched_inj[c][node*F +: F] = f;
  endtask

  task automatic place_ej(input int c, input int node, input logic [F-1:0] f);
    sched_ej[c][node*F +: F] = f;
  endtask

  // Play the injection table cycle by cycle and compare every eject/ready
  // sample against the expected table. The ring must be idle afterwards.
  task automatic run_sched(input int sel, input string name, input int ncyc);
    logic [4*F-1:0] obs_ej;
    logic [3:0]     obs_rdy;
    logic           obs_busy;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (sel == 4) inj4 = sched_inj[c];
      else          inj3 = sched_inj[c][3*F-1:0];
      @(negedge clk);
      if (sel == 4) begin obs_ej = ej4; obs_rdy = rdy4; end
      else begin obs_ej = {{F{1'b0}}, ej3}; obs_rdy = {1'b0, rdy3}; end
      checks++;
      if (obs_ej !== sched_ej[c]) begin
        errors++;
        $display("FAIL %s eject cycle %0d: got %h expected %h", name, c, obs_ej, sched_ej[c]);
      end
      checks++;
      if (obs_rdy !== sched_rdy[c]) begin
        errors++;
        $display("FAIL %s ready cycle %0d: got %b expected %b", name, c, obs_rdy, sched_rdy[c]);
      end
    end
    @(posedge clk); #1;
    inj4 = '0;
    inj3 = '0;
    @(negedge clk);
    obs_busy = (sel == 4) ? busy4 : busy3;
    checks++;
    if (obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after: got %b expected 0", name, obs_busy);
    end
  endtask

  task automatic test_reset;
    rst4 = 1'b1;
    rst3 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) inj4[i*F +: F] = make_flit(i, (i + 1) % 4);
      for (int i = 0; i < 3; i++) inj3[i*F +: F] = make_flit(i, (i + 1) % 3);
      @(negedge clk);
      checks++;
      if (ej4 !== '0 || drop4 !== 8'd0 || rdy4 !== 4'h0 || busy4 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold4 cycle %0d: ej=%h drop=%0d rdy=%b busy=%b expected all 0", c, ej4, drop4, rdy4, busy4);
      end
      checks++;
      if (ej3 !== '0 || drop3 !== 8'd0 || rdy3 !== 3'h0 || busy3 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold3 cycle %0d: ej=%h drop=%0d rdy=%b busy=%b expected all 0", c, ej3, drop3, rdy3, busy3);
      end
    end
    @(posedge clk); #1;
    rst4 = 1'b0;
    rst3 = 1'b0;
    inj4 = '0;
    inj3 = '0;
    @(negedge clk);
    checks++;
    if (rdy4 !== 4'hF || busy4 !== 1'b0 || ej4 !== '0) begin
      errors++;
      $display("FAIL reset_after4: rdy=%b busy=%b ej=%h expected rdy=1111 busy=0 ej=0", rdy4, busy4, ej4);
    end
    checks++;
    if (rdy3 !== 3'h7 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_after3: rdy=%b busy=%b expected rdy=111 busy=0", rdy3, busy3);
    end
  endtask

  task automatic test_single_hop;
    logic [F-1:0] f;
    clear_sched(4);
    f = make_flit(0, 1);
    f[71:40] = 32'h0000_0ABC;
    place_inj(0, 0, f);
    place_ej(3, 1, f);
    run_sched(4, "single_hop", 8);
  endtask

  task automatic test_wrap_distance;
    logic [F-1:0] a, b, s;
    clear_sched(4);
    a = make_flit(3, 0);   // 1 hop across the wrap link
    b = make_flit(0, 3);   // 3 hops
    s = make_flit(2, 2);   // self-addressed
    place_inj(0, 3, a);
    place_inj(0, 0, b);
    place_inj(0, 2, s);
    place_ej(3, 0, a);
    place_ej(5, 3, b);
    place_ej(2, 2, s);
    run_sched(4, "wrap_distance", 10);
  endtask

  task automatic test_priority;
    logic [F-1:0] a, h;
    clear_sched(4);
    a = make_flit(0, 2);   // reaches node1 in cycle 2
    h = make_flit(1, 3);   // node1 head is ready in cycle 2, yields one cycle
    place_inj(0, 0, a);
    place_inj(1, 1, h);
    place_ej(4, 2, a);
    place_ej(6, 3, h);
    run_sched(4, "priority", 10);
  endtask

  task automatic test_fifo_full;
    logic [F-1:0] s, p;
    clear_sched(4);
    // node3 -> node1 every cycle 0..11 occupies node0's outgoing slot in cycles 2..13
    for (int k = 0; k < 12; k++) begin
      s = make_flit(3, 1);
      place_inj(k, 3, s);
      place_ej(k + 4, 1, s);
    end
    // node0 offers five flits in cycles 2..6; four fit and the fifth is refused
    for (int j = 0; j < 5; j++) begin
      p = make_flit(0, 2);
      place_inj(2 + j, 0, p);
      if (j < 4) place_ej(17 + j, 2, p);
    end
    for (int c = 6; c <= 14; c++) sched_rdy[c] = 4'b1110;
    run_sched(4, "fifo_full", 24);
  endtask

  task automatic test_link_delay;
    logic [F-1:0] a, b, s;
    clear_sched(3);
    a = make_flit(0, 2);   // 2 hops * 2 stages
    b = make_flit(2, 0);   // 1 hop over the wrap link
    s = make_flit(1, 1);
    place_inj(0, 0, a);
    place_inj(0, 2, b);
    place_inj(0, 1, s);
    place_ej(6, 2, a);
    place_ej(4, 0, b);
    place_ej(2, 1, s);
    run_sched(3, "link_delay2", 10);
  endtask

  task automatic test_drop;
    int total;
    int len;
    int expv;
    clear_sched(3);
    place_inj(0, 1, make_flit(1, 3));
    run_sched(3, "drop_single", 6);
    checks++;
    if (drop3 !== 8'd1) begin
      errors++;
      $display("FAIL drop_single count: got %0d expected 1", drop3);
    end
    total = 1;
    for (int ph = 0; ph < 2; ph++) begin
      len = (ph == 0) ? 10 : 80;
      for (int n = 0; n < len; n++) begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) inj3[i*F +: F] = make_flit(i, 3);
        @(negedge clk);
        checks++;
        if (rdy3 !== 3'b111) begin
          errors++;
          $display("FAIL drop_burst ready: got %b expected 111", rdy3);
        end
        total += 3;
      end
      @(posedge clk); #1;
      inj3 = '0;
      repeat (3) @(negedge clk);
      expv = (total > 255) ? 255 : total;
      checks++;
      if (drop3 !== 8'(expv) || ej3 !== '0) begin
        errors++;
        $display("FAIL drop_saturate phase %0d: count %0d ej %h expected count %0d ej 0", ph, drop3, ej3, expv);
      end
    end
  endtask

  task automatic test_midflight_reset;
    @(posedge clk); #1;
    inj3 = '0;
    inj3[0 +: F] = make_flit(0, 2);
    @(posedge clk); #1;
    inj3 = '0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy3 !== 1'b1) begin
      errors++;
      $display("FAIL midreset busy_before: got %b expected 1", busy3);
    end
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(negedge clk);
    checks++;
    if (ej3 !== '0 || rdy3 !== 3'b000 || busy3 !== 1'b0 || drop3 !== 8'd0) begin
      errors++;
      $display("FAIL midreset during: ej=%h rdy=%b busy=%b drop=%0d expected all 0", ej3, rdy3, busy3, drop3);
    end
    @(posedge clk); #1;
    rst3 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (ej3 !== '0 || busy3 !== 1'b0 || drop3 !== 8'd0 || rdy3 !== 3'b111) begin
        errors++;
        $display("FAIL midreset after cycle %0d: ej=%h busy=%b drop=%0d rdy=%b expected 0/0/0/111", c, ej3, busy3, drop3, rdy3);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    logic [F-1:0] offer [4];
    logic [F-1:0] obs;
    int           found;
    int           cyc;
    logic [1:0]   d2;
    exp_q.delete();
    cyc = 0;
    while (cyc < 400 || (exp_q.size() > 0 && cyc < 800)) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (cyc < 400 && $urandom_range(0, 99) < 40) offer[i] = make_flit(i, $urandom_range(0, 3));
        else offer[i] = '0;
        inj4[i*F +: F] = offer[i];
      end
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        obs = ej4[d*F +: F];
        d2  = 2'(d);
        if (obs !== '0) begin
          found = -1;
          for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k][9:8] == obs[9:8] && exp_q[k][1:0] == obs[1:0]) begin
              found = k;
              break;
            end
          end
          checks++;
          if (found < 0) begin
            errors++;
            $display("FAIL random_eject node %0d: got %h with no outstanding match", d, obs);
          end else begin
            if (exp_q[found] !== obs || obs[1:0] !== d2) begin
              errors++;
              $display("FAIL random_eject node %0d: got %h expected %h", d, obs, exp_q[found]);
            end
            exp_q.delete(found);
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (offer[i][VB] && rdy4[i]) exp_q.push_back(offer[i]);
      end
      cyc++;
    end
    @(posedge clk); #1;
    inj4 = '0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain outstanding: got %0d expected 0", exp_q.size());
    end
    checks++;
    if (busy4 !== 1'b0 || drop4 !== 8'd0) begin
      errors++;
      $display("FAIL random_idle: busy=%b drop=%0d expected 0/0", busy4, drop4);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    inj4 = '0;
    inj3 = '0;
    test_reset();
    test_single_hop();
    test_wrap_distance();
    test_priority();
    test_fifo_full();
    test_link_delay();
    test_drop();
    test_midflight_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/torus_ring_channel.md
Name: torus_ring_channel

Overview:
- Parametrised single-dimension torus ring of NUM_NODES routers joined by pipelined unidirectional links, with a wrap-around link from the last node back to node 0.
- Each node has a local injection FIFO and a registered ejection port.
- Bufferless in-ring transport: in-transit flits always take priority over local injection.
- Successor to the fixed two-node xpos wiring of the network top; one instance per torus dimension.

Parameters:
- NUM_NODES, 4, nodes on the ring (>=2).
- LG_NODES, 2, width of destination field; 2^LG_NODES >= NUM_NODES.
- FLIT_SIZE, 82, flit width; valid bit at FLIT_SIZE-1.
- DST_LSB, 0, LSB of destination-node field, flit[DST_LSB +: LG_NODES].
- LINK_DELAY, 1, register stages per link (>=1).
- INJ_DEPTH, 4, injection FIFO entries per node (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high; single clock domain.
- inject_flit  in  NUM_NODES*FLIT_SIZE  node i slice [i*FLIT_SIZE +: FLIT_SIZE]; offered when its valid bit is 1.
- inject_ready  out  NUM_NODES  bit i = node i FIFO can accept this cycle.
- eject_flit  out  NUM_NODES*FLIT_SIZE  registered delivered flit per node; all-zero when idle.
- drop_count  out  8  saturating count of flits discarded for out-of-range destination.
- ring_busy  out  1  any link stage or FIFO holds a valid flit.

Behaviour:
Reset:
- rst high clears all FIFOs, link stages, eject registers and drop_count.
- Outputs during reset: inject_ready=0, eject_flit=0, drop_count=0, ring_busy=0.
- The first cycle after reset deasserts: inject_ready = all ones.
- Reset mid-operation discards every in-flight flit; no eject results from pre-reset traffic.

Injection:
- Accept = valid bit & inject_ready[i]; the flit is written into FIFO i at the clock edge.
- inject_ready[i] = !full, combinational from registered state.
- A push into a full FIFO is never accepted, even if a pop occurs in the same cycle.
- Inputs with valid bit 0 are ignored.

Link:
- Node i output feeds stage 0 of link i; link i's last stage is the arrival A at node (i+1) mod NUM_NODES.
- Stages shift every cycle; there is no stall.

Per node, per cycle, in priority order:
1. A valid, dst==i: A goes to the eject register; the outgoing slot is empty.
2. A valid, dst!=i: A is forwarded into link stage 0; the FIFO head waits.
3. Otherwise the slot is free; the FIFO head H, if present, is handled as follows:
   - dst>=NUM_NODES: pop and discard; drop_count increments, saturating at 255.
   - dst==i, and no arrival ejected this cycle: pop H into the eject register.
   - dst==i, but an arrival is ejected this cycle: H waits.
   - otherwise: pop H into link stage 0.

Ejection and flit content:
- eject_flit slice is valid for exactly one cycle per delivered flit; it is zero otherwise.
- Flits are never modified in flight.

Latency:
- Uncontended, empty FIFO, h hops: a flit offered in cycle 0 appears on eject_flit in cycle 2 + h*LINK_DELAY.
- Self-addressed (h=0): cycle 2.

Ordering and progress:
- Same source and same destination: delivered in order.
- No flit is ever lost except out-of-range drops.
- Injection starvation under continuous through-traffic is permitted.

ring_busy: OR of all link-stage valid bits and all FIFO-nonempty flags, combinational.

Test Plan:
1. Reset: hold rst 3 cycles with inject valid on all nodes -> eject_flit=0, drop_count=0, inject_ready=0 during reset; inject_ready=4'b1111 and ring_busy=0 after.
2. Single hop (defaults): node0 injects dst=1, payload 0xABC in cycle 0 -> eject_flit slice 1 equals that flit in cycle 3 only; all other slices 0.
3. Wrap and distance: node3 injects dst=0 -> node0 ejects in cycle 3; node0 injects dst=3 -> node3 ejects in cycle 5; LINK_DELAY=2 -> cycles 4 and 8.
4. Priority: node0 flit dst=2 arrives at node1 in the same cycle node1's head (dst=3) is ready -> head leaves one cycle later; both delivered; node1 eject slice stays 0.
5. FIFO full: node3 streams dst=1 every cycle (blocks node0); node0 offers 5 flits on consecutive cycles -> 4 accepted, inject_ready[0]=0 on the fifth; after the stream stops, all 4 are delivered in order.
6. Drop and mid-flight reset: NUM_NODES=3, inject dst=3 -> drop_count=1, no eject anywhere; then inject dst=2 and pulse rst before arrival -> no eject, ring_busy=0.
